pow2_scale_stage: RTL
=====================

POW2_SCALE_STAGE -- requirements
Module: pow2_scale_stage

Interface
REQ-001 Parameter SHIFT, default 6, power-of-two divisor exponent applied to both components (output = input / 2^SHIFT), legal range 1..8.
REQ-002 Parameter FRAME_LEN, default 125, complex samples per FFT frame (5^3), legal range 2..4096.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  upstream butterfly sample present.
REQ-006 in_ready  output  1  block accepts sample this cycle.
REQ-007 a_re  input  32  IEEE-754 single real part.
REQ-008 a_img  input  32  IEEE-754 single imaginary part.
REQ-009 out_valid  output  1  scaled sample present.
REQ-010 out_ready  input  1  downstream accepts sample.
REQ-011 a1_re  output  32  scaled real part.
REQ-012 a1_img  output  32  scaled imaginary part.
REQ-013 out_last  output  1  sample is last of frame.
REQ-014 frame_uflow  output  1  valid with out_last: some component of this frame flushed to zero.

Function
REQ-015 Transfer occurs on in_valid&in_ready (input) and out_valid&out_ready (output).
REQ-016 Two-stage pipeline (S1, S2), stall-all: advance = !out_valid | out_ready; in_ready = advance.
REQ-017 Latency exactly 2 cycles from input transfer to out_valid under no backpressure; throughput 1 sample/cycle.
REQ-018 Per component: sign bit always passed unchanged.
REQ-019 Exponent 255 (Inf/NaN): word passed unchanged.
REQ-020 Exponent 0 (zero/denormal): output sign followed by 31 zero bits; not counted as underflow.
REQ-021 Exponent 1..SHIFT: output signed zero, underflow event.
REQ-022 Exponent > SHIFT: exponent minus SHIFT, 23-bit mantissa unchanged.
REQ-023 S1 registers decoded class and raw fields; S2 registers final words; no combinational path from a_re/a_img to outputs.
REQ-024 Frame counter counts accepted inputs 0..FRAME_LEN-1, wraps to 0 after FRAME_LEN-1; last tag = (count == FRAME_LEN-1) travels with sample.
REQ-025 Underflow sticky accumulates per frame across accepted samples; frame_uflow = sticky OR current sample's underflow when out_last; sticky clears on output transfer of last sample, a simultaneous underflow on the next frame's first sample sets it.
REQ-026 frame_uflow is 0 whenever out_last is 0.
REQ-027 Outputs held stable while out_valid & !out_ready.

Reset
REQ-028 While rst_n=0 at a clock edge: out_valid=0, out_last=0, frame_uflow=0, a1_re=a1_img=0, frame counter=0, sticky=0, pipeline valid bits=0.
REQ-029 in_ready=0 during reset cycles; first acceptance possible in the cycle after rst_n returns 1.
REQ-030 Reset mid-frame discards in-flight samples; next accepted sample is index 0.

Structure
REQ-031 Shared package fft_fp_pkg holds float field widths/positions, EXP_INF=255, defaults SHIFT=6, FRAME_LEN=125, and class enum {ZERO, NORMAL, UFLOW, SPECIAL}.
REQ-032 One sub-module fp_pow2_scale (combinational, one 32-bit component, outputs word and underflow flag), instantiated twice.

Verification
REQ-033 a_re=0x42800000 (64.0), a_img=0xC2800000 -> 2 cycles later a1_re=0x3F800000, a1_img=0xBF800000, frame_uflow=0.
REQ-034 a_re=0x03000000 (exp 6), a_img=0x7FC00000 (NaN) -> a1_re=0x00000000, a1_img=0x7FC00000; underflow recorded.
REQ-035 125 back-to-back samples, underflow only at index 3 -> out_last high on 125th output only, frame_uflow=1 there; next frame clean -> frame_uflow=0.
REQ-036 out_ready toggled random 50%, 300 samples -> output sequence identical to unstalled run, no loss/duplication, outputs stable while stalled.
REQ-037 rst_n=0 for one cycle after 40 samples accepted -> all outputs 0 next cycle; subsequent 125 samples produce out_last exactly on the 125th.
REQ-038 a_re=0x80000000 (-0), a_img=0x00000001 (denormal) -> a1_re=0x80000000, a1_img=0x00000000, no underflow flagged.

Source files
------------

// File: rtl/fft_fp_pkg.sv
// Shared definitions for the FFT floating-point datapath.
//
// Holds the IEEE-754 single-precision field layout, the reserved
// all-ones exponent, the default scaling parameters, and the class
// enumeration used to steer the power-of-two scaling logic. The
// classify() helper maps a raw exponent to its handling class for a
// given shift amount.
package fft_fp_pkg;

    localparam int SIGN_BIT  = 31;
    localparam int EXP_MSB   = 30;
    localparam int EXP_LSB   = 23;
    localparam int EXP_W     = 8;
    localparam int MANT_W    = 23;

    localparam logic [EXP_W-1:0] EXP_INF = 8'd255;

    localparam int DEFAULT_SHIFT     = 6;
    localparam int DEFAULT_FRAME_LEN = 125;

    typedef enum logic [1:0] {
        ZERO,
        NORMAL,
        UFLOW,
        SPECIAL
    } fp_class_t;

    // Exponents 1..shift fall below the smallest normal after scaling,
    // so they are flushed rather than turned into denormals.
    function automatic fp_class_t classify(input logic [EXP_W-1:0] exp_field,
                                           input logic [EXP_W-1:0] shift);
        fp_class_t cls;
        if (exp_field == EXP_INF) begin
            cls = SPECIAL;
        end else if (exp_field == '0) begin
            cls = ZERO;
        end else if (exp_field <= shift) begin
            cls = UFLOW;
        end else begin
            cls = NORMAL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fp_pow2_scale.sv
// Combinational divide-by-2^SHIFT for one IEEE-754 single component.
//
// Ports:
//   word   - raw 32-bit input component
//   cls    - precomputed class of word (from fft_fp_pkg::classify)
//   scaled - scaled 32-bit component
//   uflow  - high when a normal value was flushed to signed zero
module fp_pow2_scale
    import fft_fp_pkg::*;
#(
    parameter int SHIFT = DEFAULT_SHIFT
) (
    input  logic [31:0] word,
    input  fp_class_t   cls,
    output logic [31:0] scaled,
    output logic        uflow
);

    localparam logic [EXP_W-1:0] SHIFT_E = EXP_W'(SHIFT);

    // Sign is preserved in every class; only NORMAL touches the exponent,
    // and the class guarantees the subtraction cannot wrap.
    always_comb begin
        scaled = word;
        uflow  = 1'b0;
        case (cls)
            ZERO: begin
                scaled = {word[SIGN_BIT], 31'b0};
            end
            UFLOW: begin
                scaled = {word[SIGN_BIT], 31'b0};
                uflow  = 1'b1;
            end
            NORMAL: begin
                scaled = {word[SIGN_BIT],
                          word[EXP_MSB:EXP_LSB] - SHIFT_E,
                          word[MANT_W-1:0]};
            end
            default: begin
                scaled = word;
            end
        endcase
    end

endmodule

// File: rtl/pow2_scale_stage.sv
// Two-stage pipelined power-of-two scaler for complex FFT samples.
//
// Each accepted complex sample is divided by 2^SHIFT per component.
// Samples are tagged with the last-of-frame marker, and the last sample
// of each frame reports whether any component in that frame underflowed.
//
// Ports:
//   clk, rst_n          - clock and synchronous active-low reset
//   in_valid, in_ready  - input handshake
//   a_re, a_img         - input real/imaginary components (IEEE-754)
//   out_valid, out_ready- output handshake
//   a1_re, a1_img       - scaled real/imaginary components
//   out_last            - sample is last of its frame
//   frame_uflow         - with out_last: frame saw an underflow flush
module pow2_scale_stage
    import fft_fp_pkg::*;
#(
    parameter int SHIFT     = DEFAULT_SHIFT,
    parameter int FRAME_LEN = DEFAULT_FRAME_LEN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a_re,
    input  logic [31:0] a_img,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] a1_re,
    output logic [31:0] a1_img,
    output logic        out_last,
    output logic        frame_uflow
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [EXP_W-1:0] SHIFT_E  = EXP_W'(SHIFT);

    logic             advance;
    logic             accept;
    logic [CNT_W-1:0] frame_cnt;
    logic             sticky;

    logic             s1_valid;
    logic             s1_last;
    logic [31:0]      s1_re;
    logic [31:0]      s1_img;
    fp_class_t        s1_re_cls;
    fp_class_t        s1_img_cls;

    logic [31:0]      scaled_re;
    logic [31:0]      scaled_img;
    logic             uflow_re;
    logic             uflow_img;
    logic             s1_uflow;

    // Whole pipeline stalls together when the output is held.
    assign advance  = !out_valid || out_ready;
    assign in_ready = rst_n && advance;
    assign accept   = in_valid && in_ready;

    fp_pow2_scale #(.SHIFT(SHIFT)) u_scale_re (
        .word   (s1_re),
        .cls    (s1_re_cls),
        .scaled (scaled_re),
        .uflow  (uflow_re)
    );

    fp_pow2_scale #(.SHIFT(SHIFT)) u_scale_img (
        .word   (s1_img),
        .cls    (s1_img_cls),
        .scaled (scaled_img),
        .uflow  (uflow_img)
    );

    assign s1_uflow = uflow_re || uflow_img;

    // Index of the next accepted sample within its frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (accept) begin
            frame_cnt <= (frame_cnt == LAST_IDX) ? '0 : frame_cnt + 1'b1;
        end
    end

    // Stage 1: capture raw words, their classes and the last-of-frame tag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            s1_re      <= '0;
            s1_img     <= '0;
            s1_re_cls  <= ZERO;
            s1_img_cls <= ZERO;
        end else if (advance) begin
            s1_valid <= accept;
            if (accept) begin
                s1_last    <= (frame_cnt == LAST_IDX);
                s1_re      <= a_re;
                s1_img     <= a_img;
                s1_re_cls  <= classify(a_re[EXP_MSB:EXP_LSB], SHIFT_E);
                s1_img_cls <= classify(a_img[EXP_MSB:EXP_LSB], SHIFT_E);
            end
        end
    end

    // Stage 2: register the scaled words. The frame sticky is folded in as
    // each sample enters this stage; it restarts once the last sample of a
    // frame has been loaded, so the following frame's first sample can set
    // it again on the same edge the last sample is transferred out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            frame_uflow <= 1'b0;
            a1_re       <= '0;
            a1_img      <= '0;
            sticky      <= 1'b0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                a1_re       <= scaled_re;
                a1_img      <= scaled_img;
                out_last    <= s1_last;
                frame_uflow <= s1_last && (sticky || s1_uflow);
                sticky      <= s1_last ? 1'b0 : (sticky || s1_uflow);
            end
        end
    end

endmodule
